// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg -- definitions shared by the CPU pipeline blocks.
//
// Contents:
//   WORD_W         datapath width (16 bits)
//   mem_state_t    MEM-stage access sequencer states (IDLE / WAIT / DONE)
//   mem_req_t      request captured when a data-memory access is launched
//   access_pending whether the instruction in MEM needs the data memory
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // no access in flight; decides whether to launch one
    WAIT = 2'd1,  // request on the bus, waiting for dmem_ack
    DONE = 2'd2   // access finished; pipeline released for one cycle
  } mem_state_t;

  typedef struct packed {
    logic              we;     // 1 = store, 0 = load
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
  } mem_req_t;

  // A cancelled (flushed) instruction never reaches the memory.
  function automatic logic access_pending(input logic rd,
                                          input logic wr,
                                          input logic flush);
    return (rd | wr) & ~flush;
  endfunction

endpackage

// File: rtl/mem_wdog.sv
// ---------------------------------------------------------------------------
// mem_wdog -- WAIT-cycle watchdog for the MEM stage.
//
// Counts consecutive cycles with i_run high and flags the cycle in which the
// TIMEOUT_CYCLES-th such cycle is being spent. The count restarts whenever
// i_run drops, so every access gets a fresh budget.
//
// Parameters:
//   TIMEOUT_CYCLES  number of WAIT cycles allowed before abort (>= 1)
// Ports:
//   clk       clock, rising edge
//   reset     asynchronous, active-low reset (clears the count)
//   i_run     high while the access sequencer sits in WAIT
//   o_expire  high during the last permitted WAIT cycle
// ---------------------------------------------------------------------------
module mem_wdog #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic i_run,
  output logic o_expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;

  // r_cnt holds the number of WAIT cycles already completed, so the limit is
  // reached while the count still reads TIMEOUT_CYCLES-1.
  assign o_expire = i_run & (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // NOTE: clocked state is assigned with <= so every register samples the
  // pre-edge values; blocking = here would create order-dependent behaviour.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (!i_run) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage -- MEM pipeline stage: sequences one data-memory access per
// instruction and stalls the pipeline until it completes.
//
// Sequencer: IDLE -> WAIT (request on bus until dmem_ack) -> DONE -> IDLE.
// The request (address, data, direction) is captured on entry to WAIT and
// held stable on the bus for the whole WAIT period. A load and store request
// together is executed as a store.
//
// Build option:
//   MEM_TIMEOUT_EN  when defined, a watchdog (mem_wdog) aborts an access after
//                   TIMEOUT_CYCLES WAIT cycles without ack: rdata_mem becomes
//                   16'hFFFF and bus_err pulses for the DONE cycle. An ack in
//                   the limit cycle still completes normally. When undefined,
//                   WAIT lasts until ack and bus_err is constant 0.
//
// Ports:
//   clk            clock, rising edge
//   reset          asynchronous, active-low reset
//   memread_mem    load requested by the instruction in MEM
//   memwrite_mem   store requested by the instruction in MEM
//   flush_mem      cancel the MEM instruction (only looked at in IDLE)
//   addr_mem       data address
//   wdata_mem      store data
//   dmem_req       request valid (high exactly in WAIT)
//   dmem_we        request is a store
//   dmem_addr      request address
//   dmem_wdata     request store data
//   dmem_ack       memory completion (only looked at in WAIT)
//   dmem_rdata     memory read data, valid with dmem_ack
//   stall_mem      freeze upstream stages / hold MEM/WB enable low
//   rdata_mem      last load result (held until the next load completes)
//   bus_err        one-cycle timeout pulse
// ---------------------------------------------------------------------------
module mem_stage
  import cpu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memread_mem,
  input  logic              memwrite_mem,
  input  logic              flush_mem,
  input  logic [WORD_W-1:0] addr_mem,
  input  logic [WORD_W-1:0] wdata_mem,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [WORD_W-1:0] dmem_addr,
  output logic [WORD_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [WORD_W-1:0] dmem_rdata,
  output logic              stall_mem,
  output logic [WORD_W-1:0] rdata_mem,
  output logic              bus_err
);

  localparam logic [WORD_W-1:0] ABORT_DATA = '1;

  mem_state_t        r_state;
  mem_state_t        w_state_nxt;
  mem_req_t          r_req;
  mem_req_t          w_req_nxt;
  logic [WORD_W-1:0] r_rdata;
  logic [WORD_W-1:0] w_rdata_nxt;
  logic              w_pending;
  logic              w_in_wait;
  logic              w_expire;
  logic              w_timeout_hit;

  assign w_pending = access_pending(memread_mem, memwrite_mem, flush_mem);
  assign w_in_wait = (r_state == WAIT);

`ifdef MEM_TIMEOUT_EN
  mem_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk      (clk),
    .reset    (reset),
    .i_run    (w_in_wait),
    .o_expire (w_expire)
  );
`else
  assign w_expire = 1'b0;
`endif

  // An ack arriving in the limit cycle takes priority over the abort.
  assign w_timeout_hit = w_in_wait & ~dmem_ack & w_expire;

  // NOTE: every signal written in this block gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_req;
    w_rdata_nxt = r_rdata;

    unique case (r_state)
      IDLE: begin
        if (w_pending) begin
          w_req_nxt.we    = memwrite_mem;  // load+store together -> store
          w_req_nxt.addr  = addr_mem;
          w_req_nxt.wdata = wdata_mem;
          w_state_nxt     = WAIT;
        end
      end

      WAIT: begin
        if (dmem_ack) begin
          if (!r_req.we) begin
            w_rdata_nxt = dmem_rdata;
          end
          w_state_nxt = DONE;
        end else if (w_timeout_hit) begin
          w_rdata_nxt = ABORT_DATA;
          w_state_nxt = DONE;
        end
      end

      DONE: begin
        // The instruction leaves MEM this cycle; a following access is only
        // considered once back in IDLE.
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_req   <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= w_req_nxt;
      r_rdata <= w_rdata_nxt;
    end
  end

`ifdef MEM_TIMEOUT_EN
  logic r_bus_err;

  // DONE lasts exactly one cycle, so registering the abort gives a pulse
  // aligned with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bus_err <= 1'b0;
    end else begin
      r_bus_err <= w_timeout_hit;
    end
  end

  assign bus_err = r_bus_err;
`else
  assign bus_err = 1'b0;
`endif

  assign dmem_req   = w_in_wait;
  assign dmem_we    = w_in_wait & r_req.we;
  assign dmem_addr  = r_req.addr;
  assign dmem_wdata = r_req.wdata;
  assign rdata_mem  = r_rdata;

  // The IDLE term depends on live inputs, so it is qualified with reset to
  // keep the stall low while reset is held.
  assign stall_mem = reset & (w_in_wait | ((r_state == IDLE) & w_pending));

endmodule
